cache_req_ctrl: RTL and testbench

Request front-end for one cache set array. Accepts single CPU load/store requests over a valid/ready handshake and splits the 36-bit address into tag/set/offset. Sequences the set array's enable / write_enable / force_write controls, waits for its op_done, and returns read data or a miss/error status. On a write miss it performs write-allocate by reissuing the write as a force write.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_req_ctrl_if.sv | 50 +++++
 rtl/cache_addr_decode.sv | 28 ++
 rtl/cache_req_ctrl.sv | 152 +++++++++++++++
 tb/tb_cache_req_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for cache request front-ends: address field layout,
// access-size encoding, controller states and size helpers.
package cache_pkg;

    localparam int TAG_W  = 24;
    localparam int SET_W  = 6;
    localparam int OFF_W  = 6;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FILL,
        S_FILL_WAIT,
        S_RESP
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/cache_req_ctrl_if.sv
// CPU request/response handshake plus the set-array control bus.
interface cache_req_ctrl_if #(
    parameter int ADDR_W = 36
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [63:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_miss;
    logic              resp_err;

    logic              set_enable;
    logic              set_write_enable;
    logic              set_force_write;
    logic [23:0]       set_tag;
    logic [5:0]        set_idx;
    logic [5:0]        set_offset;
    logic [1:0]        set_size;
    logic [63:0]       set_wdata;
    logic [31:0]       set_n_ops;
    logic              set_op_done;
    logic              set_data_ready;
    logic              set_read_miss;
    logic              set_write_miss;
    logic [127:0]      set_out_data;

    // Controller side
    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
               set_op_done, set_data_ready, set_read_miss, set_write_miss, set_out_data,
        output req_ready, resp_valid, resp_rdata, resp_miss, resp_err,
               set_enable, set_write_enable, set_force_write, set_tag, set_idx,
               set_offset, set_size, set_wdata, set_n_ops
    );

    // CPU + set-array side
    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
               set_op_done, set_data_ready, set_read_miss, set_write_miss, set_out_data,
        input  req_ready, resp_valid, resp_rdata, resp_miss, resp_err,
               set_enable, set_write_enable, set_force_write, set_tag, set_idx,
               set_offset, set_size, set_wdata, set_n_ops
    );
endinterface

// File: rtl/cache_addr_decode.sv
// Splits a byte address into tag/set/offset and flags accesses that are
// not naturally aligned or that run past the end of the line.
module cache_addr_decode
    import cache_pkg::*;
#(
    parameter int ADDR_W = 36
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    output logic [TAG_W-1:0]  tag,
    output logic [SET_W-1:0]  set_idx,
    output logic [OFF_W-1:0]  offset,
    output logic              misaligned
);
    localparam int SPAN_W = OFF_W + 1;

    logic [3:0]        nbytes;
    logic [SPAN_W-1:0] span_end;

    assign nbytes   = size_bytes(size);
    assign tag      = addr[OFF_W+SET_W +: TAG_W];
    assign set_idx  = addr[OFF_W +: SET_W];
    assign offset   = addr[OFF_W-1:0];
    assign span_end = {1'b0, offset} + SPAN_W'(nbytes);

    assign misaligned = ((offset & OFF_W'(nbytes - 4'd1)) != '0)
                     || (span_end > SPAN_W'(1 << OFF_W));
endmodule

// File: rtl/cache_req_ctrl.sv
// Single-outstanding request front-end for one cache set array, with
// write-allocate on store miss and a per-operation completion timeout.
module cache_req_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 36,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    cache_req_ctrl_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e             state, state_nx;
    logic               wr_q;
    logic [TAG_W-1:0]   tag_q;
    logic [SET_W-1:0]   set_q;
    logic [OFF_W-1:0]   off_q;
    logic [1:0]         size_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q, rdata_nx;
    logic               miss_q, miss_nx, err_q, err_nx;
    logic [TMO_W-1:0]   tmo_q, tmo_nx;
    logic [31:0]        n_ops_q;

    logic [TAG_W-1:0]   dec_tag;
    logic [SET_W-1:0]   dec_set;
    logic [OFF_W-1:0]   dec_off;
    logic               dec_misaligned;
    logic               accept;
    logic               tmo_hit;
    logic               unused_hi;

    cache_addr_decode #(.ADDR_W(ADDR_W)) u_dec (
        .addr       (bus.req_addr),
        .size       (bus.req_size),
        .tag        (dec_tag),
        .set_idx    (dec_set),
        .offset     (dec_off),
        .misaligned (dec_misaligned)
    );

    assign accept    = bus.req_valid & bus.req_ready;
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign unused_hi = ^bus.set_out_data[127:64];

    always_comb begin
        state_nx = state;
        rdata_nx = rdata_q;
        miss_nx  = miss_q;
        err_nx   = err_q;
        tmo_nx   = tmo_q;
        case (state)
            S_IDLE: if (accept) begin
                rdata_nx = '0;
                miss_nx  = 1'b0;
                err_nx   = dec_misaligned;
                state_nx = dec_misaligned ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                tmo_nx   = '0;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.set_op_done) begin
                    state_nx = S_RESP;
                    if (bus.set_read_miss && bus.set_write_miss) begin
                        err_nx = 1'b1;
                    end else if (bus.set_read_miss) begin
                        miss_nx = 1'b1;
                    end else if (bus.set_write_miss && wr_q) begin
                        state_nx = S_FILL;
                    end else if (!wr_q && bus.set_data_ready) begin
                        rdata_nx = bus.set_out_data[DATA_W-1:0] & size_mask(size_q);
                    end
                end else if (tmo_hit) begin
                    err_nx   = 1'b1;
                    state_nx = S_RESP;
                end else begin
                    tmo_nx = tmo_q + 1'b1;
                end
            end
            S_FILL: begin
                tmo_nx   = '0;
                state_nx = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                // A forced write that still misses means the array is wedged.
                if (bus.set_op_done) begin
                    err_nx   = bus.set_write_miss;
                    state_nx = S_RESP;
                end else if (tmo_hit) begin
                    err_nx   = 1'b1;
                    state_nx = S_RESP;
                end else begin
                    tmo_nx = tmo_q + 1'b1;
                end
            end
            S_RESP: if (bus.resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            tag_q   <= '0;
            set_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            n_ops_q <= '0;
        end else begin
            state   <= state_nx;
            rdata_q <= rdata_nx;
            miss_q  <= miss_nx;
            err_q   <= err_nx;
            tmo_q   <= tmo_nx;
            if (accept) begin
                wr_q    <= bus.req_write;
                tag_q   <= dec_tag;
                set_q   <= dec_set;
                off_q   <= dec_off;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
            end
            if (state == S_ISSUE || state == S_FILL) n_ops_q <= n_ops_q + 32'd1;
        end
    end

    // Set controls decode straight from state so reset drops them at once.
    assign bus.req_ready        = (state == S_IDLE) & ~rst;
    assign bus.set_enable       = (state == S_ISSUE) || (state == S_FILL);
    assign bus.set_write_enable = (state == S_ISSUE) & wr_q;
    assign bus.set_force_write  = (state == S_FILL);
    assign bus.set_tag          = tag_q;
    assign bus.set_idx          = set_q;
    assign bus.set_offset       = off_q;
    assign bus.set_size         = size_q;
    assign bus.set_wdata        = wdata_q;
    assign bus.set_n_ops        = n_ops_q;
    assign bus.resp_valid       = (state == S_RESP);
    assign bus.resp_rdata       = rdata_q;
    assign bus.resp_miss        = miss_q;
    assign bus.resp_err         = err_q;
endmodule

// File: tb/tb_cache_req_ctrl.sv
// Bench for cache_req_ctrl: set-array stub, directed vector table, random
// transactions against a reference model, timeout and reset sequences.
module tb_cache_req_ctrl;
    localparam int TMO = 16;

    typedef struct {
        logic        wr;
        logic [35:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        int          kind;
        int          dly;
        logic        fkind;
        logic        respond;
        logic [63:0] odata;
        logic [63:0] e_rdata;
        logic        e_miss;
        logic        e_err;
        int          e_lat;
        int          e_ops;
        int          e_force;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_req_ctrl_if bus ();

    cache_req_ctrl #(.ADDR_W(36), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Set-array stub configuration and observations
    int          stub_kind = 0;
    int          stub_dly = 0;
    logic        stub_fkind = 1'b0;
    logic        stub_respond = 1'b1;
    logic [63:0] stub_data = '0;
    int          n_en = 0;
    int          n_force = 0;
    logic [63:0] force_wdata = '0;
    logic [23:0] force_tag = '0;
    bit          pend = 0;
    bit          pend_fill = 0;
    bit          pend_we = 0;
    int          pend_cnt = 0;
    bit          st_done = 0, st_dr = 0, st_rm = 0, st_wm = 0;
    logic [127:0] st_data = '0;

    assign bus.set_op_done    = st_done;
    assign bus.set_data_ready = st_dr;
    assign bus.set_read_miss  = st_rm;
    assign bus.set_write_miss = st_wm;
    assign bus.set_out_data   = st_data;

    always @(negedge clk) begin
        st_done = 0; st_dr = 0; st_rm = 0; st_wm = 0;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (pend_cnt == 0) begin
                    pend = 0;
                    st_done = 1;
                    if (pend_fill) st_wm = stub_fkind;
                    else case (stub_kind)
                        0: st_dr = !pend_we;
                        1: st_rm = 1;
                        2: st_wm = 1;
                        default: begin st_rm = 1; st_wm = 1; end
                    endcase
                end else pend_cnt--;
            end
            if (bus.set_enable) begin
                n_en++;
                if (bus.set_force_write) begin
                    n_force++;
                    force_wdata = bus.set_wdata;
                    force_tag   = bus.set_tag;
                end
                pend      = stub_respond;
                pend_cnt  = stub_dly;
                pend_fill = bus.set_force_write;
                pend_we   = bus.set_write_enable;
                st_data   = {~stub_data, stub_data};
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [35:0] addr, input logic [1:0] size,
                                input logic [63:0] wdata, input int kind, input int dly,
                                input logic fkind, input logic [63:0] odata,
                                input logic [63:0] e_rdata, input logic e_miss, input logic e_err,
                                input int e_lat, input int e_ops, input int e_force);
        vec_t v;
        v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.kind = kind;
        v.dly = dly; v.fkind = fkind; v.respond = 1'b1; v.odata = odata;
        v.e_rdata = e_rdata; v.e_miss = e_miss; v.e_err = e_err;
        v.e_lat = e_lat; v.e_ops = e_ops; v.e_force = e_force;
        return v;
    endfunction

    // Reference behaviour from the request rules, independent of state encoding
    function automatic vec_t model(input vec_t vin);
        vec_t v = vin;
        int nb  = 1 << v.size;
        int off = int'(v.addr[5:0]);
        v.e_rdata = '0; v.e_miss = 0; v.e_err = 0;
        v.e_ops = 1; v.e_force = 0; v.e_lat = 3 + v.dly;
        if ((off % nb) != 0 || off + nb > 64) begin
            v.e_err = 1; v.e_ops = 0; v.e_lat = 1;
        end else if (!v.respond) begin
            v.e_err = 1; v.e_lat = 2 + TMO;
        end else if (v.kind == 3) begin
            v.e_err = 1;
        end else if (v.kind == 1) begin
            v.e_miss = 1;
        end else if (v.kind == 2) begin
            v.e_ops = 2; v.e_force = 1; v.e_lat = 5 + 2 * v.dly; v.e_err = v.fkind;
        end else if (!v.wr) begin
            v.e_rdata = (nb == 8) ? v.odata : v.odata % (64'd1 << (8 * nb));
        end
        return v;
    endfunction

    int model_ops = 0;

    task automatic run_vec(input vec_t v, input string nm, input int hold);
        int lat, en0, f0;
        stub_kind = v.kind; stub_dly = v.dly; stub_fkind = v.fkind;
        stub_respond = v.respond; stub_data = v.odata;
        en0 = n_en; f0 = n_force;
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = v.wr; bus.req_addr = v.addr;
        bus.req_size = v.size; bus.req_wdata = v.wdata;
        chk({nm, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            chk({nm, " req_ready busy"}, 64'(bus.req_ready), 64'd0);
            if (bus.resp_valid) break;
        end
        chk({nm, " latency"}, 64'(lat), 64'(v.e_lat));
        chk({nm, " rdata"}, bus.resp_rdata, v.e_rdata);
        chk({nm, " miss"}, 64'(bus.resp_miss), 64'(v.e_miss));
        chk({nm, " err"}, 64'(bus.resp_err), 64'(v.e_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, " hold valid"}, 64'(bus.resp_valid), 64'd1);
            chk({nm, " hold rdata"}, bus.resp_rdata, v.e_rdata);
            chk({nm, " hold err"}, 64'(bus.resp_err), 64'(v.e_err));
            chk({nm, " hold miss"}, 64'(bus.resp_miss), 64'(v.e_miss));
        end
        bus.resp_ready = 1;
        @(posedge clk);
        #1 bus.resp_ready = 0;
        chk({nm, " resp_valid drop"}, 64'(bus.resp_valid), 64'd0);
        chk({nm, " req_ready back"}, 64'(bus.req_ready), 64'd1);
        model_ops += v.e_ops;
        chk({nm, " n_ops"}, 64'(bus.set_n_ops), 64'(model_ops));
        chk({nm, " enable pulses"}, 64'(n_en - en0), 64'(v.e_ops));
        chk({nm, " force pulses"}, 64'(n_force - f0), 64'(v.e_force));
        if (v.e_force != 0) begin
            chk({nm, " force wdata"}, force_wdata, v.wdata);
            chk({nm, " force tag"}, 64'(force_tag), 64'(v.addr[35:12]));
        end
    endtask

    vec_t tbl[11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int nb;
        logic [5:0] off;
        logic [63:0] od = 64'h1122334455667788;

        tbl[0]  = mk(0, {24'd1, 6'd0, 6'd8}, 2'd3, 64'h0, 0, 0, 0, 64'hDEADBEEF_CAFEF00D,
                     64'hDEADBEEF_CAFEF00D, 0, 0, 3, 1, 0);
        tbl[1]  = mk(0, {24'd2, 6'd5, 6'd0}, 2'd2, 64'h0, 1, 1, 0, od, 64'h0, 1, 0, 4, 1, 0);
        tbl[2]  = mk(1, {24'd3, 6'd9, 6'd16}, 2'd3, 64'h55, 2, 0, 0, od, 64'h0, 0, 0, 5, 2, 1);
        tbl[3]  = mk(0, {24'd4, 6'd1, 6'd6}, 2'd2, 64'h0, 0, 0, 0, od, 64'h0, 0, 1, 1, 0, 0);
        tbl[4]  = mk(0, {24'd5, 6'd2, 6'd63}, 2'd0, 64'h0, 0, 0, 0, od, 64'h88, 0, 0, 3, 1, 0);
        tbl[5]  = mk(0, {24'd6, 6'd3, 6'd2}, 2'd1, 64'h0, 0, 2, 0, od, 64'h7788, 0, 0, 5, 1, 0);
        tbl[6]  = mk(1, {24'd7, 6'd4, 6'd4}, 2'd2, 64'hABCD, 0, 0, 0, od, 64'h0, 0, 0, 3, 1, 0);
        tbl[7]  = mk(0, {24'd8, 6'd5, 6'd8}, 2'd3, 64'h0, 3, 0, 0, od, 64'h0, 0, 1, 3, 1, 0);
        tbl[8]  = mk(1, {24'd9, 6'd6, 6'd0}, 2'd3, 64'h77, 2, 1, 1, od, 64'h0, 0, 1, 7, 2, 1);
        tbl[9]  = mk(0, {24'd10, 6'd7, 6'd63}, 2'd1, 64'h0, 0, 0, 0, od, 64'h0, 0, 1, 1, 0, 0);
        tbl[10] = mk(0, {24'd11, 6'd8, 6'd60}, 2'd2, 64'h0, 0, 0, 0, od, 64'h55667788, 0, 0, 3, 1, 0);

        rst = 1;
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0;
        bus.req_size = '0; bus.req_wdata = '0; bus.resp_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset set_enable", 64'(bus.set_enable), 64'd0);
        chk("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("reset n_ops", 64'(bus.set_n_ops), 64'd0);
        chk("reset set_wdata", bus.set_wdata, 64'd0);
        rst = 0;
        #1 chk("req_ready after reset", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i), i % 3);

        for (int i = 0; i < 40; i++) begin
            v.wr = 1'($urandom_range(0, 1));
            v.size = 2'($urandom_range(0, 3));
            nb = 1 << v.size;
            if ($urandom_range(0, 3) == 0) off = 6'($urandom_range(0, 63));
            else off = 6'(($urandom_range(0, 63) / nb) * nb);
            v.addr = {24'($urandom), 6'($urandom), off};
            v.wdata = {$urandom, $urandom};
            v.odata = {$urandom, $urandom};
            v.dly = $urandom_range(0, 3);
            v.fkind = ($urandom_range(0, 4) == 0);
            v.respond = 1'b1;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: v.kind = 0;
                5, 6, 7:       v.kind = v.wr ? 2 : 1;
                default:       v.kind = 3;
            endcase
            v = model(v);
            run_vec(v, $sformatf("rand%0d", i), $urandom_range(0, 2));
        end

        // Array never answers
        v = mk(0, {24'd12, 6'd9, 6'd0}, 2'd3, 64'h0, 0, 0, 0, od, 64'h0, 0, 0, 0, 0, 0);
        v.respond = 1'b0;
        v = model(v);
        run_vec(v, "timeout", 3);

        // Reset while waiting on the array
        stub_respond = 0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = 0; bus.req_addr = {24'd13, 6'd1, 6'd0}; bus.req_size = 2'd3;
        @(posedge clk);
        #1 bus.req_valid = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        chk("rst wait set_enable", 64'(bus.set_enable), 64'd0);
        chk("rst wait resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst wait n_ops", 64'(bus.set_n_ops), 64'd0);
        model_ops = 0;
        @(negedge clk);
        rst = 0;
        #1 chk("rst wait req_ready", 64'(bus.req_ready), 64'd1);
        repeat (2) @(negedge clk);
        chk("rst wait no resp", 64'(bus.resp_valid), 64'd0);
        run_vec(tbl[0], "after reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
